awg_dac_spi: RTL and testbench

AWG_DAC_SPI -- requirements
Module: awg_dac_spi

---
 rtl/awg_dac_spi.sv | 142 ++++++++++++++
 tb/tb_awg_dac_spi.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/awg_dac_spi.sv
// AWG sample to serial DAC bridge: 16-bit SPI frames {CFG, sample},
// one-entry holding register, LDAC strobe after each frame.
module awg_dac_spi #(
    parameter int unsigned CLK_DIV = 2,
    parameter logic [3:0]  CFG     = 4'b0011
) (
    input  logic        ck,
    input  logic        rst,
    input  logic [11:0] sample,
    input  logic        valid,
    output logic        ready,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    output logic        ldac_n,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CSHI,
        LDAC
    } state_t;

    localparam logic [7:0] LP_TM1 = 8'(CLK_DIV - 1);

    state_t      r_state;
    logic [7:0]  r_div;
    logic [4:0]  r_bit;
    logic [15:0] r_shift;
    logic [11:0] r_hold;
    logic        r_full;
    logic        r_cs_n;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_ldac_n;
    logic        r_ovr;

    logic        w_last;
    logic        w_ldac_end;
    logic        w_start;
    logic        w_wr_hold;
    logic [15:0] w_frame;

    assign w_last     = (r_div == LP_TM1);
    assign w_ldac_end = (r_state == LDAC) && w_last;
    assign w_start    = ((r_state == IDLE) && (r_full || valid)) ||
                        (w_ldac_end && r_full);
    // A held sample always goes out before a freshly arriving one.
    assign w_frame    = r_full ? {CFG, r_hold} : {CFG, sample};
    assign w_wr_hold  = valid && !((r_state == IDLE) && !r_full);

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state  <= IDLE;
            r_div    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_hold   <= '0;
            r_full   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_ldac_n <= 1'b1;
            r_ovr    <= 1'b0;
        end else begin
            // Overwriting a full register is an overrun unless it drains now.
            if (w_wr_hold) begin
                r_hold <= sample;
                r_full <= 1'b1;
                if (r_full && !w_start)
                    r_ovr <= 1'b1;
            end else if (w_start && r_full) begin
                r_full <= 1'b0;
            end

            if (w_start) begin
                r_state  <= SHIFT;
                r_shift  <= w_frame;
                r_mosi   <= w_frame[15];
                r_cs_n   <= 1'b0;
                r_sclk   <= 1'b0;
                r_ldac_n <= 1'b1;
                r_bit    <= '0;
                r_div    <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_div <= '0;
                    end
                    SHIFT: begin
                        if (!w_last) begin
                            r_div <= r_div + 8'd1;
                        end else if (!r_sclk) begin
                            r_div  <= '0;
                            r_sclk <= 1'b1;
                        end else if (r_bit == 5'd15) begin
                            r_div   <= '0;
                            r_state <= CSHI;
                            r_cs_n  <= 1'b1;
                            r_sclk  <= 1'b0;
                            r_mosi  <= 1'b0;
                        end else begin
                            r_div   <= '0;
                            r_bit   <= r_bit + 5'd1;
                            r_sclk  <= 1'b0;
                            r_mosi  <= r_shift[14];
                            r_shift <= {r_shift[14:0], 1'b0};
                        end
                    end
                    CSHI: begin
                        if (w_last) begin
                            r_div    <= '0;
                            r_state  <= LDAC;
                            r_ldac_n <= 1'b0;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    LDAC: begin
                        if (w_last) begin
                            r_div    <= '0;
                            r_state  <= IDLE;
                            r_ldac_n <= 1'b1;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign ready   = !r_full;
    assign cs_n    = r_cs_n;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
    assign ldac_n  = r_ldac_n;
    assign overrun = r_ovr;

endmodule

// File: tb/tb_awg_dac_spi.sv
// Bench for awg_dac_spi: directed scenarios plus randomized traffic
// against a frame-timeline reference model, at CLK_DIV=2 and CLK_DIV=1.
module tb_awg_dac_spi;

    localparam logic [3:0] CFG = 4'b0011;

    typedef struct {
        logic [31:0] bits;
        int nrise;
        int cs_low;
        int cr;
        int fall2;
        int la;
        int lend;
        int lcnt;
        int rdy_low;
        int ovr_first;
        int ntog;
        int stab_bad;
    } meas_t;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic [1:0]  rst = 2'b11;
    logic [1:0]  valid = 2'b00;
    logic [11:0] smp [2];
    wire  [1:0]  ready, cs_n, sclk, mosi, ldac_n, ovr;

    int n_vec = 0;
    int n_err = 0;

    awg_dac_spi #(.CLK_DIV(2), .CFG(CFG)) u_d0 (
        .ck(ck), .rst(rst[0]), .sample(smp[0]), .valid(valid[0]),
        .ready(ready[0]), .cs_n(cs_n[0]), .sclk(sclk[0]),
        .mosi(mosi[0]), .ldac_n(ldac_n[0]), .overrun(ovr[0])
    );

    awg_dac_spi #(.CLK_DIV(1), .CFG(CFG)) u_d1 (
        .ck(ck), .rst(rst[1]), .sample(smp[1]), .valid(valid[1]),
        .ready(ready[1]), .cs_n(cs_n[1]), .sclk(sclk[1]),
        .mosi(mosi[1]), .ldac_n(ldac_n[1]), .overrun(ovr[1])
    );

    function automatic int td(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Reference model: frame = 34T-cycle timeline, counted down.
    int          m_rem [2] = '{0, 0};
    logic        m_full [2] = '{1'b0, 1'b0};
    logic        m_ovr [2] = '{1'b0, 1'b0};
    logic [11:0] m_hold [2];
    logic [15:0] m_frm [2];
    int          t_rem;
    logic        t_full, t_ovr;
    logic [11:0] t_hold;
    logic [15:0] t_frm;

    always @(posedge ck) begin
        for (int d = 0; d < 2; d++) begin
            t_rem = m_rem[d]; t_full = m_full[d]; t_ovr = m_ovr[d];
            t_hold = m_hold[d]; t_frm = m_frm[d];
            if (rst[d]) begin
                t_rem = 0; t_full = 1'b0; t_ovr = 1'b0;
            end else if (t_rem <= 1 && t_full) begin
                t_frm = {CFG, t_hold};
                t_rem = 34 * td(d);
                t_full = valid[d];
                if (valid[d]) t_hold = smp[d];
            end else if (t_rem == 0 && valid[d]) begin
                t_frm = {CFG, smp[d]};
                t_rem = 34 * td(d);
            end else begin
                if (t_rem > 0) t_rem = t_rem - 1;
                if (valid[d]) begin
                    if (t_full) t_ovr = 1'b1;
                    t_hold = smp[d];
                    t_full = 1'b1;
                end
            end
            m_rem[d] <= t_rem; m_full[d] <= t_full; m_ovr[d] <= t_ovr;
            m_hold[d] <= t_hold; m_frm[d] <= t_frm;
        end
    end

    // Expected {cs_n, sclk, mosi, ldac_n} for the current cycle.
    function automatic logic [3:0] exp_o(input int d);
        int i, t;
        t = td(d);
        if (m_rem[d] == 0) return 4'b1001;
        i = 34 * t - m_rem[d];
        if (i < 32 * t)
            return {1'b0, ((i / t) % 2) == 1, m_frm[d][15 - i / (2 * t)], 1'b1};
        if (i < 33 * t) return 4'b1001;
        return 4'b1000;
    endfunction

    task automatic capture(input int d, input int ncyc, input int inj_c,
                           input int inj_n, input logic [11:0] v0,
                           input logic [11:0] v1, output meas_t m);
        logic pcs, psc, pmo;
        m = '{bits: '0, cr: -1, fall2: -1, la: -1, lend: -1,
              ovr_first: -1, default: 0};
        pcs = 1'b1; psc = 1'b0; pmo = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge ck);
            if (!cs_n[d]) m.cs_low++;
            if (cs_n[d] && !pcs && m.cr < 0) m.cr = c;
            if (!cs_n[d] && pcs && m.cr >= 0 && m.fall2 < 0) m.fall2 = c;
            if (sclk[d] && !psc) begin
                m.bits = {m.bits[30:0], mosi[d]};
                m.nrise++;
            end
            if (c > 0 && !cs_n[d] && sclk[d] !== psc) m.ntog++;
            if (mosi[d] !== pmo && sclk[d] !== 1'b0) m.stab_bad++;
            if (!ldac_n[d]) begin
                if (m.la < 0) m.la = c;
                m.lcnt++;
                m.lend = c;
            end
            if (!ready[d]) m.rdy_low++;
            if (ovr[d] && m.ovr_first < 0) m.ovr_first = c;
            pcs = cs_n[d]; psc = sclk[d]; pmo = mosi[d];
            if (c >= inj_c && c < inj_c + inj_n) begin
                valid[d] = 1'b1;
                smp[d] = (c == inj_c) ? v0 : v1;
            end else begin
                valid[d] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 2'b11; valid = 2'b11;
        smp[0] = 12'($urandom); smp[1] = 12'($urandom);
        repeat (3) @(negedge ck);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({cs_n[d], sclk[d], mosi[d], ldac_n[d], ready[d], ovr[d]} !== 6'b100110) begin
                n_err++;
                $display("FAIL reset d%0d: got cs/sclk/mosi/ldac/rdy/ovr=%b want 100110", d,
                         {cs_n[d], sclk[d], mosi[d], ldac_n[d], ready[d], ovr[d]});
            end
        end
        rst = 2'b00; valid = 2'b00;
        repeat (2) @(negedge ck);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({cs_n[d], sclk[d], mosi[d], ldac_n[d], ready[d]} !== 5'b10011) begin
                n_err++;
                $display("FAIL idle d%0d: got %b want 10011", d,
                         {cs_n[d], sclk[d], mosi[d], ldac_n[d], ready[d]});
            end
        end
    endtask

    task automatic test_single();
        meas_t m;
        @(negedge ck);
        valid[0] = 1'b1; smp[0] = 12'hAE3;
        capture(0, 90, -1, 0, '0, '0, m);
        n_vec++;
        if (m.bits[15:0] !== 16'h3AE3 || m.nrise != 16) begin
            n_err++;
            $display("FAIL single_bits: got %h (%0d rises) want 3ae3 (16)", m.bits[15:0], m.nrise);
        end
        n_vec++;
        if (m.cs_low != 64 || m.cr != 64) begin
            n_err++;
            $display("FAIL single_cs: got low=%0d rise@%0d want 64/64", m.cs_low, m.cr);
        end
        n_vec++;
        if (m.la != 66 || m.lcnt != 2 || m.lend + 1 != 68) begin
            n_err++;
            $display("FAIL single_ldac: got start=%0d cnt=%0d end=%0d want 66/2/67",
                     m.la, m.lcnt, m.lend);
        end
        n_vec++;
        if (m.stab_bad != 0) begin
            n_err++;
            $display("FAIL single_mosi_stable: got %0d violations want 0", m.stab_bad);
        end
    endtask

    task automatic test_back_to_back();
        meas_t m;
        @(negedge ck);
        valid[0] = 1'b1; smp[0] = 12'h000;
        capture(0, 150, 10, 1, 12'hFFF, '0, m);
        n_vec++;
        if (m.bits !== 32'h3000_3FFF || m.nrise != 32) begin
            n_err++;
            $display("FAIL b2b_bits: got %h want 30003fff", m.bits);
        end
        n_vec++;
        if (m.fall2 != 68 || m.lend != 135) begin
            n_err++;
            $display("FAIL b2b_timing: got fall2=%0d ldac_end=%0d want 68/135", m.fall2, m.lend);
        end
        n_vec++;
        if (m.ovr_first != -1) begin
            n_err++;
            $display("FAIL b2b_overrun: got set@%0d want never", m.ovr_first);
        end
    endtask

    task automatic test_overrun();
        meas_t m;
        @(negedge ck);
        valid[0] = 1'b1; smp[0] = 12'h001;
        capture(0, 150, 0, 2, 12'h002, 12'h003, m);
        n_vec++;
        if (m.bits !== 32'h3001_3003 || m.fall2 != 68) begin
            n_err++;
            $display("FAIL ovr_frames: got %h fall2=%0d want 30013003/68", m.bits, m.fall2);
        end
        n_vec++;
        if (m.ovr_first != 2 || ovr[0] !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_flag: got first=%0d now=%b want 2/1", m.ovr_first, ovr[0]);
        end
        n_vec++;
        if (m.rdy_low != 67) begin
            n_err++;
            $display("FAIL ovr_ready: got %0d low cycles want 67", m.rdy_low);
        end
        rst[0] = 1'b1;
        @(negedge ck);
        rst[0] = 1'b0;
        n_vec++;
        if (ovr[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clear: got %b want 0", ovr[0]);
        end
    endtask

    task automatic test_abort();
        meas_t m;
        int lows;
        logic [11:0] s;
        @(negedge ck);
        valid[0] = 1'b1; smp[0] = 12'($urandom);
        for (int c = 0; c < 30; c++) begin
            @(negedge ck);
            valid[0] = 1'b0;
            if (c == 29) rst[0] = 1'b1;
        end
        @(negedge ck);
        rst[0] = 1'b0;
        n_vec++;
        if ({cs_n[0], sclk[0], mosi[0], ready[0], ldac_n[0]} !== 5'b10011) begin
            n_err++;
            $display("FAIL abort_reset: got cs/sclk/mosi/rdy/ldac=%b want 10011",
                     {cs_n[0], sclk[0], mosi[0], ready[0], ldac_n[0]});
        end
        lows = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge ck);
            if (!ldac_n[0] || !cs_n[0]) lows++;
        end
        n_vec++;
        if (lows != 0) begin
            n_err++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", lows);
        end
        s = 12'($urandom);
        valid[0] = 1'b1; smp[0] = s;
        capture(0, 80, -1, 0, '0, '0, m);
        n_vec++;
        if (m.bits[15:0] !== {CFG, s} || m.cs_low != 64 || m.la != 66 || m.lcnt != 2) begin
            n_err++;
            $display("FAIL abort_next: got %h low=%0d la=%0d lc=%0d want %h/64/66/2",
                     m.bits[15:0], m.cs_low, m.la, m.lcnt, {CFG, s});
        end
    endtask

    task automatic test_div1();
        meas_t m;
        @(negedge ck);
        valid[1] = 1'b1; smp[1] = 12'h5A5;
        capture(1, 45, -1, 0, '0, '0, m);
        n_vec++;
        if (m.bits[15:0] !== 16'h35A5 || m.nrise != 16) begin
            n_err++;
            $display("FAIL div1_bits: got %h want 35a5", m.bits[15:0]);
        end
        n_vec++;
        if (m.ntog != 31 || m.cs_low != 32) begin
            n_err++;
            $display("FAIL div1_sclk: got tog=%0d low=%0d want 31/32", m.ntog, m.cs_low);
        end
        n_vec++;
        if (m.la != 33 || m.lcnt != 1 || m.lend + 1 != 34 || m.stab_bad != 0) begin
            n_err++;
            $display("FAIL div1_frame: got la=%0d lc=%0d end=%0d stab=%0d want 33/1/33/0",
                     m.la, m.lcnt, m.lend, m.stab_bad);
        end
    endtask

    task automatic test_random(input int d, input int ncyc);
        logic [3:0] e;
        logic pmo;
        pmo = mosi[d];
        for (int c = 0; c < ncyc; c++) begin
            @(negedge ck);
            e = exp_o(d);
            n_vec++;
            if ({cs_n[d], sclk[d], mosi[d], ldac_n[d]} !== e) begin
                n_err++;
                $display("FAIL rand_pins d%0d c%0d: got %b want %b", d, c,
                         {cs_n[d], sclk[d], mosi[d], ldac_n[d]}, e);
            end
            n_vec++;
            if (ready[d] !== !m_full[d] || ovr[d] !== m_ovr[d]) begin
                n_err++;
                $display("FAIL rand_flags d%0d c%0d: got rdy=%b ovr=%b want %b %b", d, c,
                         ready[d], ovr[d], !m_full[d], m_ovr[d]);
            end
            n_vec++;
            if (mosi[d] !== pmo && sclk[d] !== 1'b0) begin
                n_err++;
                $display("FAIL rand_mosi_stable d%0d c%0d: got change with sclk=%b want sclk=0",
                         d, c, sclk[d]);
            end
            pmo = mosi[d];
            rst[d] = ($urandom_range(0, 599) == 0);
            valid[d] = ($urandom_range(0, 99) < 3);
            smp[d] = 12'($urandom);
        end
        rst[d] = 1'b0; valid[d] = 1'b0;
    endtask

    initial begin
        smp[0] = '0; smp[1] = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_div1();
        test_random(0, 3000);
        test_random(1, 2000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
